multiplexer_4x4: RTL and testbench
==================================

# multiplexer_4x4

Registered 4-input, WIDTH-bit multiplexer selecting one of four data words (I1..I4) with a 2-bit select split across two single-bit ports (sbit1 = MSB, sbit0 = LSB). The selected word is captured on the rising clock edge and held on `out` until the next edge. It is a leaf datapath element for steering one of four operand/status words onto a shared bus. It holds no state beyond the output register and the valid flag.

## Interface
- WIDTH, 4, bit width of each data input and of `out`; legal range 1..64.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; clears all state immediately.
- I1  input  WIDTH  data word selected when {sbit1,sbit0} = 2'b00.
- I2  input  WIDTH  data word selected when {sbit1,sbit0} = 2'b01.
- I3  input  WIDTH  data word selected when {sbit1,sbit0} = 2'b10.
- I4  input  WIDTH  data word selected when {sbit1,sbit0} = 2'b11.
- sbit0  input  1  select LSB.
- sbit1  input  1  select MSB.
- out  output  WIDTH  registered selected word.
- out_valid  output  1  high from the first rising edge after reset release; low while in reset.

## Operation
- Select code sel = {sbit1, sbit0}; the mapping is fixed and exhaustive: 00 -> I1, 01 -> I2, 10 -> I3, 11 -> I4.
- Combinational next value `nxt` = word chosen by sel; no arithmetic, no width change; bits pass through unmodified (bit i of `out` = bit i of the chosen input).
- Every rising clk edge with rst_n high: out <= nxt; out_valid <= 1.
- No enable, no hold input: `out` updates every cycle.
- If sel contains X/Z (simulation only), `out` keeps its previous value; it must not propagate X because of an unknown select alone.
- X/Z on a selected data input propagates to `out`. X/Z on an unselected input has no effect.
- Reset (rst_n low, any time, including mid-operation): out = 0 and out_valid = 0 immediately, without waiting for a clock edge. Both stay 0 while rst_n is low.
- Reset release: the first rising edge with rst_n high loads `nxt` and sets out_valid.

## Timing
- Latency: 1 clk cycle from a change of sel or data to its appearance on `out`. Inputs must be stable for setup/hold around the rising edge.
- Reset values: out = {WIDTH{1'b0}}, out_valid = 0.
- Simultaneous change of sel and data before an edge: `out` reflects the new sel applied to the new data.
- sel changing every cycle: `out` follows with 1-cycle lag and no dropped or repeated values.
- No combinational path from inputs to outputs.
- Single clock domain; no CDC logic inside the block.

## Test plan
- Reset: drive rst_n = 0 mid-cycle with out previously 4'd14 -> out = 0 and out_valid = 0 immediately (before the next edge); both remain 0 while rst_n is low.
- Full select sweep, WIDTH = 4, I1 = 4'b1011, I2 = 4'b1100, I3 = 4'b1101, I4 = 4'b1110. Apply sel 00, 01, 10, 11, holding each for ≥ 2 cycles. Sampled out must read 11, 12, 13, 14 respectively, one cycle after each sel change; out_valid = 1.
- Data tracking: hold sel = 10, change I3 from 4'd13 to 4'd3. Out reads 13 until the next edge, then 3. Changing I1, I2 and I4 leaves out at 3.
- Back-to-back select: sel toggles 00, 11, 01, 10 on consecutive cycles with the sweep data. Out must read 11, 14, 12, 13 on consecutive cycles with exactly 1-cycle lag.
- Reset release: deassert rst_n with sel = 01 and I2 = 4'd12. Out stays 0 until the first rising edge, then reads 12, with out_valid rising on that same edge.
- Parameter check: WIDTH = 8, I4 = 8'hA5, sel = 11 -> out = 8'hA5 after 1 cycle.

Source files
------------

// File: rtl/multiplexer_4x4.sv
// Registered 4-input, WIDTH-bit multiplexer with a split 2-bit select.
// Steers one of four operand/status words onto a shared bus with one cycle of latency.
module multiplexer_4x4 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] I1,
   input  logic [WIDTH-1:0] I2,
   input  logic [WIDTH-1:0] I3,
   input  logic [WIDTH-1:0] I4,
   input  logic             sbit0,
   input  logic             sbit1,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);

   localparam int unsigned SEL_W = 2;

   logic [SEL_W-1:0] sel;
   logic [WIDTH-1:0] nxt;

   assign sel = {sbit1, sbit0};

   // Next-value select; an unknown select falls to default and holds the current output.
   always_comb begin
      nxt = out;
      case (sel)
         2'b00:   nxt = I1;
         2'b01:   nxt = I2;
         2'b10:   nxt = I3;
         2'b11:   nxt = I4;
         default: nxt = out;
      endcase
   end

   // Output register and valid flag, cleared immediately on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= WIDTH'(0);
         out_valid <= 1'b0;
      end else begin
         out       <= nxt;
         out_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multiplexer_4x4.sv
// Directed self-checking bench for multiplexer_4x4 (WIDTH = 4 and WIDTH = 8 instances).
module tb_multiplexer_4x4;

   logic       clk;
   logic       rst_n;
   logic [3:0] i1, i2, i3, i4;
   logic       sbit0, sbit1;
   logic [3:0] out;
   logic       out_valid;

   logic [7:0] w1, w2, w3, w4;
   logic       wsbit0, wsbit1;
   logic [7:0] wout;
   logic       wout_valid;

   int checks   = 0;
   int failures = 0;

   multiplexer_4x4 #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .I1(i1), .I2(i2), .I3(i3), .I4(i4),
      .sbit0(sbit0), .sbit1(sbit1),
      .out(out), .out_valid(out_valid)
   );

   multiplexer_4x4 #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .I1(w1), .I2(w2), .I3(w3), .I4(w4),
      .sbit0(wsbit0), .sbit1(wsbit1),
      .out(wout), .out_valid(wout_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sel(input logic [1:0] s);
      {sbit1, sbit0} = s;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i1 = 4'b1011; i2 = 4'b1100; i3 = 4'b1101; i4 = 4'b1110;
      set_sel(2'b00);
      w1 = 8'h3C; w2 = 8'h00; w3 = 8'hFF; w4 = 8'hA5;
      {wsbit1, wsbit0} = 2'b00;
      #2;
      checks++;
      if (out !== 4'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_init: out=%0d valid=%b expected out=0 valid=0", out, out_valid);
      end
      tick();
      checks++;
      if (out !== 4'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold: out=%0d valid=%b expected out=0 valid=0", out, out_valid);
      end
      #3;
      rst_n = 1'b1;
   endtask

   task automatic test_sweep();
      logic [1:0] sels [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [3:0] exp  [4] = '{4'd11, 4'd12, 4'd13, 4'd14};
      for (int k = 0; k < 4; k++) begin
         set_sel(sels[k]);
         for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (out !== exp[k] || out_valid !== 1'b1) begin
               failures++;
               $display("FAIL sweep sel=%b cyc=%0d: out=%0d valid=%b expected out=%0d valid=1",
                        sels[k], c, out, out_valid, exp[k]);
            end
         end
      end
   endtask

   task automatic test_data_tracking();
      set_sel(2'b10);
      tick();
      checks++;
      if (out !== 4'd13) begin
         failures++;
         $display("FAIL track_pre: out=%0d expected 13", out);
      end
      i3 = 4'd3;
      #1;
      checks++;
      if (out !== 4'd13) begin
         failures++;
         $display("FAIL track_before_edge: out=%0d expected 13", out);
      end
      tick();
      checks++;
      if (out !== 4'd3) begin
         failures++;
         $display("FAIL track_after_edge: out=%0d expected 3", out);
      end
      i1 = 4'd0; i2 = 4'd7; i4 = 4'd9;
      tick();
      tick();
      checks++;
      if (out !== 4'd3) begin
         failures++;
         $display("FAIL track_unselected: out=%0d expected 3", out);
      end
      i1 = 4'b1011; i2 = 4'b1100; i3 = 4'b1101; i4 = 4'b1110;
   endtask

   task automatic test_back_to_back();
      logic [1:0] sels [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
      logic [3:0] exp  [4] = '{4'd11, 4'd14, 4'd12, 4'd13};
      for (int k = 0; k < 4; k++) begin
         set_sel(sels[k]);
         tick();
         checks++;
         if (out !== exp[k]) begin
            failures++;
            $display("FAIL b2b step=%0d sel=%b: out=%0d expected %0d", k, sels[k], out, exp[k]);
         end
      end
   endtask

   task automatic test_midop_reset();
      set_sel(2'b11);
      tick();
      checks++;
      if (out !== 4'd14) begin
         failures++;
         $display("FAIL midrst_pre: out=%0d expected 14", out);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out !== 4'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_immediate: out=%0d valid=%b expected out=0 valid=0", out, out_valid);
      end
      tick();
      checks++;
      if (out !== 4'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_hold: out=%0d valid=%b expected out=0 valid=0", out, out_valid);
      end
   endtask

   task automatic test_reset_release();
      set_sel(2'b01);
      i2 = 4'd12;
      {wsbit1, wsbit0} = 2'b00;
      #3;
      rst_n = 1'b1;
      #1;
      checks++;
      if (out !== 4'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL release_before_edge: out=%0d valid=%b expected out=0 valid=0", out, out_valid);
      end
      tick();
      checks++;
      if (out !== 4'd12 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL release_first_edge: out=%0d valid=%b expected out=12 valid=1", out, out_valid);
      end
   endtask

   task automatic test_width8();
      checks++;
      if (wout !== 8'h3C || wout_valid !== 1'b1) begin
         failures++;
         $display("FAIL w8_sel00: out=%h valid=%b expected out=3c valid=1", wout, wout_valid);
      end
      {wsbit1, wsbit0} = 2'b11;
      #1;
      checks++;
      if (wout !== 8'h3C) begin
         failures++;
         $display("FAIL w8_before_edge: out=%h expected 3c", wout);
      end
      tick();
      checks++;
      if (wout !== 8'hA5) begin
         failures++;
         $display("FAIL w8_sel11: out=%h expected a5", wout);
      end
      {wsbit1, wsbit0} = 2'b10;
      tick();
      checks++;
      if (wout !== 8'hFF) begin
         failures++;
         $display("FAIL w8_sel10: out=%h expected ff", wout);
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_data_tracking();
      test_back_to_back();
      test_midop_reset();
      test_reset_release();
      test_width8();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
